// File: rtl/spi_pkg.sv
// Shared types and constants for the Quad-SPI read controller.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_END
  } state_t;

  localparam int unsigned CMD_BITS  = 8;
  localparam int unsigned ADDR_BITS = 24;

  localparam logic [3:0] OE_SINGLE = 4'b1101;
  localparam logic [3:0] OE_QUAD   = 4'b0000;

  function automatic logic [3:0] data_oe(input logic quad);
    return quad ? OE_QUAD : OE_SINGLE;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: half-period divider with run/stall control and edge strobes.
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic stall,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(CLK_DIV - 1));
  // Strobes mark the clk edge at which the registered sck changes level.
  assign rise = run && !stall && wrap && !sck;
  assign fall = run && !stall && wrap && sck;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!run) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!stall) begin
      if (wrap) begin
        cnt <= '0;
        sck <= ~sck;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/spi_rx_read_ctrl.sv
// Quad-SPI flash read sequencer: cmd, 24-bit address, dummy, 1/4-lane data into the RX FIFO.
module spi_rx_read_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned FIFO_DEPTH = 261,
  parameter int unsigned CS_HOLD    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [23:0] addr,
  input  logic [3:0]  dummy,
  input  logic [8:0]  len,
  input  logic        quad,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic [3:0]  spi_dq_o,
  output logic [3:0]  spi_dq_oe,
  input  logic [3:0]  spi_dq_i,
  input  logic [8:0]  fifo_count,
  output logic        fifo_wr_en,
  output logic [7:0]  fifo_data
);

  localparam int unsigned SR_BITS    = CMD_BITS + ADDR_BITS;
  localparam int unsigned END_CYCLES = CS_HOLD * CLK_DIV;
  localparam int unsigned EW         = $clog2(END_CYCLES + 1);

  state_t              state;
  logic [SR_BITS-1:0]  sreg;
  logic [4:0]          cyc_cnt;
  logic [2:0]          bit_pos;
  logic [7:0]          rx_byte;
  logic [7:0]          rx_next;
  logic [8:0]          rcv_cnt;
  logic [8:0]          len_q;
  logic [3:0]          dummy_q;
  logic                quad_q;
  logic                abort_pend;
  logic [EW-1:0]       end_cnt;
  logic [9:0]          occupancy;
  logic                run, stall, sck, rise, fall;
  logic                full, abort_go, byte_last, end_now;

  assign run       = state inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA};
  assign occupancy = {1'b0, fifo_count} + 10'(fifo_wr_en);
  assign full      = occupancy >= 10'(FIFO_DEPTH);
  assign stall     = (state == ST_DATA) && (bit_pos == '0) && !sck
                     && (rcv_cnt != len_q) && full;
  // Abort only where SCK is and stays low, so END never starts with SCK high.
  assign abort_go  = (abort || abort_pend) && ((!sck && !rise) || fall);
  assign byte_last = quad_q ? (bit_pos == 3'd1) : (bit_pos == 3'd7);
  assign rx_next   = quad_q ? {rx_byte[3:0], spi_dq_i} : {rx_byte[6:0], spi_dq_i[1]};
  assign spi_sck   = sck;

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .stall (stall),
    .sck   (sck),
    .rise  (rise),
    .fall  (fall)
  );

  always_comb begin
    end_now = 1'b0;
    if (run) begin
      if (abort_go) begin
        end_now = 1'b1;
      end else if (fall) begin
        case (state)
          ST_ADDR:  end_now = (cyc_cnt == 5'(ADDR_BITS - 1)) && (dummy_q == '0) && (len_q == '0);
          ST_DUMMY: end_now = (cyc_cnt == ({1'b0, dummy_q} - 5'd1)) && (len_q == '0);
          ST_DATA:  end_now = (rcv_cnt == len_q);
          default:  end_now = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      spi_cs_n   <= 1'b1;
      spi_dq_oe  <= '0;
      spi_dq_o   <= '0;
      fifo_wr_en <= 1'b0;
      fifo_data  <= '0;
      sreg       <= '0;
      cyc_cnt    <= '0;
      bit_pos    <= '0;
      rx_byte    <= '0;
      rcv_cnt    <= '0;
      len_q      <= '0;
      dummy_q    <= '0;
      quad_q     <= 1'b0;
      abort_pend <= 1'b0;
      end_cnt    <= '0;
    end else begin
      done       <= 1'b0;
      fifo_wr_en <= 1'b0;
      if (abort && run) abort_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_CMD;
            busy       <= 1'b1;
            spi_cs_n   <= 1'b0;
            spi_dq_oe  <= OE_SINGLE;
            spi_dq_o   <= {2'b11, 1'b0, cmd[7]};
            sreg       <= {cmd, addr};
            cyc_cnt    <= '0;
            bit_pos    <= '0;
            rcv_cnt    <= '0;
            len_q      <= len;
            dummy_q    <= dummy;
            quad_q     <= quad;
            abort_pend <= 1'b0;
          end
        end
        ST_END: begin
          if (end_cnt == EW'(END_CYCLES - 1)) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            end_cnt <= '0;
          end else begin
            end_cnt <= end_cnt + EW'(1);
          end
        end
        default: begin
          if (!abort_go) begin
            if (rise && state == ST_DATA) begin
              rx_byte <= rx_next;
              if (byte_last) begin
                fifo_wr_en <= 1'b1;
                fifo_data  <= rx_next;
                rcv_cnt    <= rcv_cnt + 9'd1;
                bit_pos    <= '0;
              end else begin
                bit_pos <= bit_pos + 3'd1;
              end
            end
            if (fall) begin
              cyc_cnt <= cyc_cnt + 5'd1;
              case (state)
                ST_CMD: begin
                  sreg        <= sreg << 1;
                  spi_dq_o[0] <= sreg[SR_BITS-2];
                  if (cyc_cnt == 5'(CMD_BITS - 1)) begin
                    state   <= ST_ADDR;
                    cyc_cnt <= '0;
                  end
                end
                ST_ADDR: begin
                  sreg        <= sreg << 1;
                  spi_dq_o[0] <= sreg[SR_BITS-2];
                  if (cyc_cnt == 5'(ADDR_BITS - 1)) begin
                    cyc_cnt   <= '0;
                    spi_dq_oe <= data_oe(quad_q);
                    spi_dq_o  <= quad_q ? 4'b0000 : 4'b1100;
                    state     <= (dummy_q != '0) ? ST_DUMMY : ST_DATA;
                  end
                end
                ST_DUMMY: begin
                  if (cyc_cnt == ({1'b0, dummy_q} - 5'd1)) begin
                    cyc_cnt <= '0;
                    state   <= ST_DATA;
                  end
                end
                default: ;
              endcase
            end
          end
          // Termination overrides any phase advance decided above on the same edge.
          if (end_now) begin
            state      <= ST_END;
            spi_cs_n   <= 1'b1;
            spi_dq_oe  <= '0;
            spi_dq_o   <= '0;
            end_cnt    <= '0;
            abort_pend <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
